// File: rtl/rom_fetch_pkg.sv
// Shared types and default parameters for the ROM fetch buffer.
// The top level and its FIFO import these.
package rom_fetch_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REWIND = 2'd1,
        FETCH  = 2'd2,
        DRAIN  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding ROM words plus their last-word tag.
// DEPTH must be a power of two, so the pointers wrap on their own.
module fetch_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is left without reset; consumers qualify the head with empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rom_fetch_buffer.sv
// Rewinds a sequential ROM, streams a requested number of words out of it
// and buffers them behind a valid/ready interface with a last-word flag.
//
//   state  | meaning
//   IDLE   | waiting for start; a zero-length start only pulses done
//   REWIND | rom_reset high for one cycle, ROM address back to 0
//   FETCH  | enable ROM whenever the FIFO has room, push each word
//   DRAIN  | all words fetched, wait for the FIFO to empty, then done
module rom_fetch_buffer
    import rom_fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  length,
    input  logic [DATA_W-1:0] rom_data,
    output logic              rom_enable,
    output logic              rom_reset,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    logic [CNT_W-1:0]  remaining;
    logic              is_last;
    logic              pop;
    logic [DATA_W:0]   fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    assign is_last    = (remaining == CNT_W'(1));
    assign rom_enable = (state == FETCH) && !fifo_full;
    assign rom_reset  = (state == REWIND);
    assign busy       = (state != IDLE);
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign out_data   = out_valid ? fifo_head[DATA_W-1:0] : '0;
    assign out_last   = out_valid && fifo_head[DATA_W];

    fetch_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rom_enable),
        .push_data ({is_last, rom_data}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // done is registered one edge early so that busy drops with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            remaining <= length;
                            state     <= REWIND;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                REWIND: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (rom_enable) begin
                        remaining <= remaining - 1'b1;
                        if (is_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty || (fifo_count == CW'(1) && pop)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_fetch_buffer.sv
// Scoreboard bench for rom_fetch_buffer driving a behavioural sequential ROM.
module tb_rom_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  length;
    logic [31:0] rom_data;
    logic        rom_enable;
    logic        rom_reset;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic [31:0] rom [16];
    logic [3:0]  rom_addr = 4'd0;

    logic [32:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          pop_cnt = 0;
    int          last_pop_cyc = 0;
    int          done_cnt = 0;
    logic        stall_prev = 1'b0;
    logic [32:0] stall_word = '0;
    logic        done_prev = 1'b0;

    rom_fetch_buffer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .length     (length),
        .rom_data   (rom_data),
        .rom_enable (rom_enable),
        .rom_reset  (rom_reset),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_reset) rom_addr <= 4'd0;
        else if (rom_enable) rom_addr <= rom_addr + 4'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), rom[i]});
        end
    endtask

    task automatic load_rom(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            rom[i] = base + 32'(i);
        end
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        int i;
        i = 0;
        while (!done && i < max_cyc) begin
            tick();
            i++;
        end
        chk(name, done, 1'b1);
    endtask

    // Monitor: compares every accepted word against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_word", {out_last, out_data}, stall_word);
            end
            if (out_valid && out_ready) begin
                chk("queue_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e[31:0]);
                    chk("out_last", out_last, e[32]);
                end
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            stall_word = {out_last, out_data};
            if (done) begin
                chk("busy_at_done", busy, 1'b0);
                chk("done_one_cycle", done_prev, 1'b0);
                done_cnt++;
            end
            done_prev = done;
        end else begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset_n   = 1'b0;
        start     = 1'b0;
        length    = 8'd0;
        out_ready = 1'b0;
        load_rom(32'h0);
        tick();
        tick();
        chk("rst_rom_enable", rom_enable, 1'b0);
        chk("rst_rom_reset", rom_reset, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        reset_n = 1'b1;
        tick();

        // Length 3, ROM = {1, 0, 0, ...}, consumer always ready
        rom[0] = 32'h1;
        out_ready = 1'b1;
        length = 8'd3;
        start = 1'b1;
        push_exp(3);
        tick();
        start = 1'b0;
        chk("t1_c1_rom_reset", rom_reset, 1'b1);
        chk("t1_c1_rom_enable", rom_enable, 1'b0);
        chk("t1_c1_busy", busy, 1'b1);
        tick();
        chk("t1_c2_rom_enable", rom_enable, 1'b1);
        chk("t1_c2_rom_reset", rom_reset, 1'b0);
        tick();
        chk("t1_c3_rom_enable", rom_enable, 1'b1);
        chk("t1_c3_out_valid", out_valid, 1'b1);
        tick();
        chk("t1_c4_rom_enable", rom_enable, 1'b1);
        tick();
        chk("t1_c5_rom_enable", rom_enable, 1'b0);
        chk("t1_c5_done", done, 1'b0);
        tick();
        chk("t1_c6_done", done, 1'b1);
        chk("t1_c6_busy", busy, 1'b0);
        chk("t1_done_after_pop", cyc - last_pop_cyc, 1);
        tick();
        chk("t1_c7_done", done, 1'b0);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Length 8 with the consumer stalled: FIFO fills to 4 then stops
        load_rom(32'hA000_0000);
        out_ready = 1'b0;
        length = 8'd8;
        start = 1'b1;
        push_exp(8);
        base = pop_cnt;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("t2_rom_addr_4", rom_addr, 4'd4);
        chk("t2_rom_enable_off", rom_enable, 1'b0);
        chk("t2_head", out_data, 32'hA000_0000);
        out_ready = 1'b1;
        wait_done(40, "t2_done_timeout");
        chk("t2_done_after_pop", cyc - last_pop_cyc, 1);
        chk("t2_pops", pop_cnt - base, 8);
        chk("t2_queue_empty", exp_q.size(), 0);
        tick();

        // Consumer toggling ready during FETCH
        load_rom(32'h3300_0010);
        out_ready = 1'b1;
        length = 8'd6;
        start = 1'b1;
        push_exp(6);
        base = pop_cnt;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b1;
        wait_done(40, "t3_done_timeout");
        chk("t3_pops", pop_cnt - base, 6);
        chk("t3_queue_empty", exp_q.size(), 0);
        tick();

        // Zero length: done next cycle, no ROM activity
        length = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_done", done, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_rom_reset", rom_reset, 1'b0);
        chk("t4_rom_enable", rom_enable, 1'b0);
        tick();
        chk("t4_done_low", done, 1'b0);
        chk("t4_busy_low", busy, 1'b0);
        chk("t4_rom_enable_low", rom_enable, 1'b0);

        // start while busy is ignored
        load_rom(32'h5500_0000);
        length = 8'd3;
        start = 1'b1;
        push_exp(3);
        base = pop_cnt;
        tick();
        length = 8'd5;
        tick();
        tick();
        start = 1'b0;
        wait_done(40, "t5_done_timeout");
        chk("t5_pops", pop_cnt - base, 3);
        tick();
        tick();
        chk("t5_idle", busy, 1'b0);
        chk("t5_no_extra", out_valid, 1'b0);
        chk("t5_queue_empty", exp_q.size(), 0);

        // Reset mid-FETCH, then a fresh request restarts from word 0
        load_rom(32'hC0DE_0000);
        length = 8'd8;
        start = 1'b1;
        push_exp(8);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        base = done_cnt;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rom_enable", rom_enable, 1'b0);
        chk("t6_rom_reset", rom_reset, 1'b0);
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_out_last", out_last, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_out_data", out_data, 32'h0);
        tick();
        tick();
        chk("t6_rom_addr_kept", rom_addr, 4'd2);
        reset_n = 1'b1;
        tick();
        chk("t6_no_done", done_cnt - base, 0);
        length = 8'd2;
        start = 1'b1;
        push_exp(2);
        base = pop_cnt;
        tick();
        start = 1'b0;
        wait_done(40, "t6_done_timeout");
        chk("t6_pops", pop_cnt - base, 2);
        chk("t6_queue_empty", exp_q.size(), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_fetch_buffer.md
# rom_fetch_buffer

Downstream consumer of the sequential 32-bit ROM (auto-incrementing address, combinational `data`). On a start command it rewinds the ROM, streams a requested number of words out of it by pulsing the ROM's `enable`, and buffers them in a small FIFO. Words are presented to the next stage on a valid/ready stream with a last-word flag, under full backpressure. It lets the ROM feed any consumer that cannot accept one word per cycle.

## Interface
- `DATA_W`, 32: ROM word width.
- `DEPTH`, 4: FIFO entries; must be a power of two and at least 2.
- `CNT_W`, 8: width of the word-count request and internal counters.

- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle command pulse; sampled only in IDLE.
- `length`  in  CNT_W: number of words to fetch; sampled with `start`.
- `rom_data`  in  DATA_W: ROM `data` output, combinational from the ROM address.
- `rom_enable`  out  1: drives the ROM `enable`; the address advances after each asserted cycle.
- `rom_reset`  out  1: drives the ROM's active-high `reset`; rewinds the ROM address to 0.
- `out_valid`  out  1: FIFO head is valid.
- `out_data`  out  DATA_W: FIFO head word.
- `out_last`  out  1: head is the final word of the request.
- `out_ready`  in  1: downstream accepts the head this cycle.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the request has been fully delivered.

## Operation
- The FSM has four states: IDLE, REWIND, FETCH and DRAIN.
- IDLE:
  - `start`=1 with `length`≠0: latch `remaining`=`length` and go to REWIND.
  - `start`=1 with `length`=0: stay in IDLE and pulse `done` on the next cycle. No ROM activity occurs.
- REWIND: `rom_reset`=1 for exactly one cycle, then go to FETCH.
- FETCH:
  - `rom_enable` = (fifo_count < DEPTH). This is registered state only, with no path from `out_ready`.
  - On each enabled cycle, push `rom_data` into the FIFO, tagged with last = (`remaining`==1), and decrement `remaining`.
  - After the push with `remaining`==1, go to DRAIN.
- DRAIN: when the FIFO is empty, pulse `done` and go to IDLE.
- FIFO behaviour:
  - Pop occurs when `out_valid` && `out_ready`.
  - A simultaneous push and pop leaves the count unchanged.
  - A push is never issued while the FIFO is full, so no overflow can occur.
  - Read and write pointers wrap modulo DEPTH.
- `start` while `busy` is ignored. It is not queued.
- `out_data` and `out_last` are don't-care while `out_valid`=0. They must be stable while `out_valid`=1 && !`out_ready`.
- Reset asserted mid-operation: the FSM returns to IDLE, the FIFO empties, and `remaining` clears. No `done` pulse is produced, and the ROM address is left as-is.

## Timing
- Reset values: `rom_enable`=0, `rom_reset`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, and `out_data`=0.
- `start` sampled at edge 0:
  - REWIND during cycle 1.
  - First `rom_enable` in cycle 2, capturing ROM word 0.
  - `out_valid` from cycle 3.
- With `out_ready` held at 1, throughput is one word per cycle. `length`=N completes with `done` in cycle N+3.
- `done` is asserted for exactly one cycle. `busy` falls in the same cycle that `done` is asserted.
- `rom_enable` and `rom_reset` are driven from registered state and FIFO count only.

## Structure
- Package `rom_fetch_pkg` holds the state enum (IDLE, REWIND, FETCH, DRAIN) and the default values of `DATA_W`, `DEPTH` and `CNT_W`.
- Sub-module `fetch_fifo` is a synchronous FIFO of width DATA_W+1 (data plus last tag) and depth DEPTH. It has push/pop/full/empty/count signals and async active-low reset.
- The top level contains the FSM, the `remaining` counter and the output glue.

## Test plan
- Reset, then `start` with `length`=3, ROM = {1, 0, 0, …}, `out_ready`=1:
  - `rom_reset` is high in cycle 1 and `rom_enable` is high in cycles 2–4.
  - Outputs are 32'h1, 0, 0, with `out_last` on the third word.
  - `done` pulses in cycle 6.
- `length`=8 with `out_ready`=0:
  - `rom_enable` drops after 4 pushes and the FIFO holds 4 words.
  - After `out_ready` rises, all 8 words drain in order.
  - `done` pulses after the 8th pop.
- `out_ready` toggling 1,0,1,0 during FETCH: no word is lost or duplicated, and `out_data` is stable across stalled cycles.
- `start` with `length`=0: `done` pulses the next cycle, `busy` never rises, and `rom_reset` and `rom_enable` stay 0.
- `start` pulsed while `busy`: it is ignored, and the word count delivered equals the first request.
- `reset_n` asserted mid-FETCH: all outputs return to reset values immediately, with no `done` pulse. A fresh `start` then fetches from ROM word 0.
